// File: rtl/rvfi_trace_buffer.sv
// RVFI retire-stream capture FIFO drained as four 32-bit words per record over a valid/ready trace port.
// Optional TRACE_ORDER_CHECK_EN adds a sticky order_err output and flags out-of-order records in HDR[23:16].
module rvfi_trace_buffer #(
  parameter int DEPTH  = 16,
  parameter int DROP_W = 16
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              rvfi_valid,
  input  logic              rvfi_trap,
  input  logic [63:0]       rvfi_order,
  input  logic [31:0]       rvfi_pc_rdata,
  input  logic [31:0]       rvfi_insn,
  input  logic [4:0]        rvfi_rd_addr,
  input  logic [31:0]       rvfi_rd_wdata,
  input  logic [3:0]        rvfi_mem_wmask,
  input  logic [3:0]        rvfi_mem_rmask,
  output logic              tr_valid,
  input  logic              tr_ready,
  output logic [31:0]       tr_data,
  output logic              tr_last,
  output logic              full,
  output logic              empty,
`ifdef TRACE_ORDER_CHECK_EN
  output logic              order_err,
`endif
  output logic [DROP_W-1:0] drop_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic        err;
    logic        trap;
    logic        wflag;
    logic        rflag;
    logic [4:0]  rd;
    logic [15:0] order;
    logic [31:0] pc;
    logic [31:0] insn;
    logic [31:0] wdata;
  } rec_t;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_PC, S_INSN, S_DATA} state_t;

  // Handshake: a word transfers on any rising CLK where tr_valid && tr_ready;
  // tr_data/tr_last are held stable while tr_valid && !tr_ready.
  state_t          state;
  rec_t            mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_nxt;
  logic            wr_en, pop, viol;
  rec_t            in_rec, head, next_head;

  function automatic logic [31:0] hdr_word(input rec_t r);
    return {r.trap, r.wflag, r.rflag, r.rd, {7'd0, r.err}, r.order};
  endfunction

  wire unused_order_hi = &{1'b0, rvfi_order[63:16]};

`ifdef TRACE_ORDER_CHECK_EN
  logic [63:0] last_order;
  logic        have_prev;
  assign viol = have_prev && (rvfi_order != last_order + 64'd1);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      last_order <= '0;
      have_prev  <= 1'b0;
      order_err  <= 1'b0;
    end else if (wr_en) begin
      last_order <= rvfi_order;
      have_prev  <= 1'b1;
      if (viol) order_err <= 1'b1;
    end
  end
`else
  assign viol = 1'b0;
`endif

  assign pop   = tr_valid && tr_ready && (state == S_DATA);
  assign wr_en = rvfi_valid && ((count < CW'(DEPTH)) || pop);
  assign head  = mem[rd_ptr];

  always_comb begin
    in_rec       = '0;
    in_rec.err   = viol;
    in_rec.trap  = rvfi_trap;
    in_rec.wflag = |rvfi_mem_wmask;
    in_rec.rflag = |rvfi_mem_rmask;
    in_rec.rd    = rvfi_rd_addr;
    in_rec.order = rvfi_order[15:0];
    in_rec.pc    = rvfi_pc_rdata;
    in_rec.insn  = rvfi_insn;
    in_rec.wdata = rvfi_rd_wdata;
  end

  always_comb begin
    count_nxt = count;
    case ({wr_en, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // A record written on the same edge as the last pop is not yet in mem, so bypass it.
  assign next_head = (count == CW'(1) && wr_en) ? in_rec : mem[rd_ptr + AW'(1)];

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr] <= in_rec;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
      drop_count <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
      if (rvfi_valid && !wr_en && drop_count != '1)
        drop_count <= drop_count + DROP_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state    <= S_IDLE;
      tr_valid <= 1'b0;
      tr_data  <= '0;
      tr_last  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (!empty) begin
          state    <= S_HDR;
          tr_valid <= 1'b1;
          tr_data  <= hdr_word(head);
        end
        S_HDR: if (tr_ready) begin
          state   <= S_PC;
          tr_data <= head.pc;
        end
        S_PC: if (tr_ready) begin
          state   <= S_INSN;
          tr_data <= head.insn;
        end
        S_INSN: if (tr_ready) begin
          state   <= S_DATA;
          tr_data <= head.wdata;
          tr_last <= 1'b1;
        end
        S_DATA: if (tr_ready) begin
          tr_last <= 1'b0;
          if (count_nxt != '0) begin
            state   <= S_HDR;
            tr_data <= hdr_word(next_head);
          end else begin
            state    <= S_IDLE;
            tr_valid <= 1'b0;
            tr_data  <= '0;
          end
        end
        default: begin
          state    <= S_IDLE;
          tr_valid <= 1'b0;
          tr_last  <= 1'b0;
        end
      endcase
    end
  end
endmodule
